// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter that time-shares one external combinational adder among
// NUM_REQ requesters, returning sum, unsigned carry and signed overflow per op.

module adder_share_lane #(
  parameter int IDX  = 0,
  parameter int ID_W = 2
) (
  input  logic            valid,
  input  logic [ID_W-1:0] rr_ptr,
  output logic            upper
);
  localparam logic [ID_W-1:0] IDX_L = ID_W'(IDX);

  // A request at or above the pointer wins over any request below it.
  assign upper = valid && (IDX_L >= rr_ptr);
endmodule

module adder_share_arbiter #(
  parameter  int NUM_REQ = 4,
  parameter  int DATA_W  = 16,
  localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_op1,
  input  logic [NUM_REQ*DATA_W-1:0] req_op2,
  output logic [DATA_W-1:0]         add_op1,
  output logic [DATA_W-1:0]         add_op2,
  input  logic [DATA_W-1:0]         add_sum,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_sum,
  output logic                      rsp_carry,
  output logic                      rsp_ovf,
  output logic                      busy
);
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
  } req_t;

  typedef struct packed {
    logic [DATA_W-1:0] sum;
    logic              carry;
    logic              ovf;
  } rsp_t;

  state_t                          state;
  req_t                            req_q;
  rsp_t                            rsp_q;
  logic [ID_W-1:0]                 rr_ptr;
  logic [NUM_REQ-1:0][DATA_W-1:0]  op1_v;
  logic [NUM_REQ-1:0][DATA_W-1:0]  op2_v;
  logic [NUM_REQ-1:0]              upper;
  logic [ID_W-1:0]                 gnt;
  logic                            any_vld;
  logic [ID_W-1:0]                 ptr_nxt;

  assign op1_v = req_op1;
  assign op2_v = req_op2;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    adder_share_lane #(.IDX(i), .ID_W(ID_W)) u_lane (
      .valid (req_valid[i]),
      .rr_ptr(rr_ptr),
      .upper (upper[i])
    );
  end

  // Lowest valid index is the wrap-around fallback; lowest index at/above the
  // pointer overrides it, giving a circular search starting at rr_ptr.
  always_comb begin
    gnt     = '0;
    any_vld = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        gnt     = ID_W'(i);
        any_vld = 1'b1;
      end
    end
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (upper[i]) gnt = ID_W'(i);
    end
  end

  always_comb begin
    req_ready = '0;
    if (!rst && state == IDLE && any_vld) req_ready[gnt] = 1'b1;
  end

  assign ptr_nxt = (req_q.id == ID_W'(NUM_REQ - 1)) ? '0 : req_q.id + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      req_q     <= '0;
      rsp_q     <= '0;
      rr_ptr    <= '0;
      rsp_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_vld) begin
            req_q.id  <= gnt;
            req_q.op1 <= op1_v[gnt];
            req_q.op2 <= op2_v[gnt];
            busy      <= 1'b1;
            state     <= EXEC;
          end
        end
        EXEC: begin
          rsp_q.sum   <= add_sum;
          rsp_q.carry <= (add_sum < req_q.op1);
          rsp_q.ovf   <= (req_q.op1[DATA_W-1] == req_q.op2[DATA_W-1]) &&
                         (add_sum[DATA_W-1] != req_q.op1[DATA_W-1]);
          rsp_valid   <= 1'b1;
          state       <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            rr_ptr    <= ptr_nxt;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  assign add_op1   = req_q.op1;
  assign add_op2   = req_q.op2;
  assign rsp_id    = req_q.id;
  assign rsp_sum   = rsp_q.sum;
  assign rsp_carry = rsp_q.carry;
  assign rsp_ovf   = rsp_q.ovf;
endmodule
